// File: rtl/sim_ctrl_pkg.sv
// Shared types and constants for the simulation-control responder:
// FSM state and done-cause encodings, default control addresses, status layout.
package sim_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } sim_state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE  = 2'd0,
        CAUSE_STOP  = 2'd1,
        CAUSE_LIMIT = 2'd2
    } done_cause_e;

    localparam int unsigned DEFAULT_STOP_ADDR      = 0;
    localparam int unsigned DEFAULT_LOG_START_ADDR = 8;
    localparam int unsigned DEFAULT_LOG_STOP_ADDR  = 16;
    localparam int unsigned DEFAULT_CYCLE_CNT_ADDR = 24;
    localparam int unsigned DEFAULT_STATUS_ADDR    = 32;

    localparam int unsigned STATUS_STATE_LSB = 0;
    localparam int unsigned STATUS_CAUSE_LSB = 2;

endpackage

// File: rtl/sim_ctrl_unit.sv
// Memory-mapped simulation-control responder: decodes stop/log control writes,
// enforces a cycle limit, and serves cycle-counter and status reads.
module sim_ctrl_unit
    import sim_ctrl_pkg::*;
#(
    parameter int unsigned AddrWidth    = 21,
    parameter int unsigned DataWidth    = 128,
    parameter int unsigned DrainCycles  = 50,
    parameter int unsigned StopAddr     = DEFAULT_STOP_ADDR,
    parameter int unsigned LogStartAddr = DEFAULT_LOG_START_ADDR,
    parameter int unsigned LogStopAddr  = DEFAULT_LOG_STOP_ADDR,
    parameter int unsigned CycleCntAddr = DEFAULT_CYCLE_CNT_ADDR,
    parameter int unsigned StatusAddr   = DEFAULT_STATUS_ADDR
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 mem_req_i,
    input  logic [AddrWidth-1:0] mem_addr_i,
    input  logic [DataWidth-1:0] mem_wdata_i,
    input  logic [DataWidth-1:0] mem_strb_i,
    input  logic                 mem_we_i,
    output logic                 hit_o,
    output logic [DataWidth-1:0] mem_rdata_o,
    input  logic [31:0]          sim_len_i,
    output logic                 log_en_o,
    output logic                 stop_req_o,
    output logic                 done_o,
    output logic [1:0]           done_cause_o,
    output logic [63:0]          cycle_cnt_o
);

    localparam int unsigned DrainW = (DrainCycles > 0) ? $clog2(DrainCycles + 1) : 1;

    localparam logic [AddrWidth-1:0] StopA     = AddrWidth'(StopAddr);
    localparam logic [AddrWidth-1:0] LogStartA = AddrWidth'(LogStartAddr);
    localparam logic [AddrWidth-1:0] LogStopA  = AddrWidth'(LogStopAddr);
    localparam logic [AddrWidth-1:0] CycleCntA = AddrWidth'(CycleCntAddr);
    localparam logic [AddrWidth-1:0] StatusA   = AddrWidth'(StatusAddr);

    sim_state_e           state_q, state_d;
    done_cause_e          cause_q, cause_d;
    logic                 log_q, log_d;
    logic [DrainW-1:0]    drain_q, drain_d;
    logic [63:0]          cycle_q, cycle_d;
    logic [DataWidth-1:0] rdata_q, rdata_d;
    logic [DataWidth-1:0] status_word;
    logic                 wr;
    logic                 limit_hit;

    // Write data and strobes carry no meaning for control addresses.
    logic unused_wdata;
    assign unused_wdata = ^{mem_wdata_i, mem_strb_i};

    assign hit_o = mem_req_i && ((mem_addr_i == StopA)     ||
                                 (mem_addr_i == LogStartA) ||
                                 (mem_addr_i == LogStopA)  ||
                                 (mem_addr_i == CycleCntA) ||
                                 (mem_addr_i == StatusA));

    assign wr        = mem_req_i && mem_we_i;
    assign limit_hit = (sim_len_i != 32'd0) && (cycle_q == (64'(sim_len_i) - 64'd1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_RUN;
            cause_q <= CAUSE_NONE;
            log_q   <= 1'b0;
            drain_q <= '0;
            cycle_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            log_q   <= log_d;
            drain_q <= drain_d;
            cycle_q <= cycle_d;
            rdata_q <= rdata_d;
        end
    end

    // The limit check takes priority over stop writes and drain expiry alike.
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        log_d   = log_q;
        drain_d = drain_q;
        cycle_d = cycle_q;

        case (state_q)
            ST_RUN: begin
                if (limit_hit) begin
                    state_d = ST_DONE;
                    cause_d = CAUSE_LIMIT;
                    log_d   = 1'b0;
                end else if (wr && (mem_addr_i == StopA)) begin
                    state_d = ST_DRAIN;
                    cause_d = CAUSE_STOP;
                    log_d   = 1'b0;
                    drain_d = DrainW'(DrainCycles);
                end else if (wr && (mem_addr_i == LogStartA)) begin
                    log_d = 1'b1;
                end else if (wr && (mem_addr_i == LogStopA)) begin
                    log_d = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (limit_hit) begin
                    state_d = ST_DONE;
                    cause_d = CAUSE_LIMIT;
                end else if (drain_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q - DrainW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        // The counter stops on the limit edge so it reads back as sim_len-1.
        if ((state_q != ST_DONE) && !limit_hit) begin
            cycle_d = cycle_q + 64'd1;
        end
    end

    always_comb begin
        status_word = '0;
        status_word[STATUS_CAUSE_LSB +: 2] = cause_q;
        status_word[STATUS_STATE_LSB +: 2] = state_q;

        rdata_d = '0;
        if (mem_req_i && !mem_we_i) begin
            if (mem_addr_i == CycleCntA) begin
                rdata_d = DataWidth'(cycle_q);
            end else if (mem_addr_i == StatusA) begin
                rdata_d = status_word;
            end
        end
    end

    assign mem_rdata_o  = rdata_q;
    assign log_en_o     = log_q && (state_q == ST_RUN);
    assign stop_req_o   = (state_q == ST_DRAIN) || (state_q == ST_DONE);
    assign done_o       = (state_q == ST_DONE);
    assign done_cause_o = cause_q;
    assign cycle_cnt_o  = cycle_q;

endmodule
